// File: rtl/bcd_to_bin_seq.sv
// Iterative reverse double-dabble BCD-to-binary converter with valid/ready on both sides.
// Optional invalid-digit detection is enabled by defining BCD_TO_BIN_ERR_CHECK_EN.
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [BIN_W-1:0]    bin_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                err
);
   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORK_W = BCD_W + BIN_W;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q;
   logic [WORK_W-1:0] work_q;
   logic [WORK_W-1:0] shifted_d;
   logic [WORK_W-1:0] work_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              out_valid_q;
   logic [BIN_W-1:0]  bin_out_q;
   logic              err_q;
   logic              err_flag_q;
   logic              bad_digit_d;

   // One iteration: shift the whole register right, then pull each digit >= 8 back by 3.
   assign shifted_d = work_q >> 1;
   assign work_d[BIN_W-1:0] = shifted_d[BIN_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] digit_d;
         assign digit_d = shifted_d[BIN_W + 4*gi +: 4];
         assign work_d[BIN_W + 4*gi +: 4] = (digit_d >= 4'd8) ? (digit_d - 4'd3) : digit_d;
      end
   endgenerate

`ifdef BCD_TO_BIN_ERR_CHECK_EN
   logic [DIGITS-1:0] digit_bad_d;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_check
         assign digit_bad_d[gi] = (bcd_in[4*gi +: 4] > 4'd9);
      end
   endgenerate
   assign bad_digit_d = |digit_bad_d;
`else
   assign bad_digit_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         work_q      <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         bin_out_q   <= '0;
         err_q       <= 1'b0;
         err_flag_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  work_q     <= {bcd_in, {BIN_W{1'b0}}};
                  cnt_q      <= '0;
                  err_flag_q <= bad_digit_d;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               work_q <= work_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  // A flagged word still runs full length so latency never depends on data.
                  bin_out_q   <= err_flag_q ? '0 : work_d[BIN_W-1:0];
                  err_q       <= err_flag_q;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  err_flag_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign bin_out   = bin_out_q;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed plus randomized bench for bcd_to_bin_seq; expected values come from decimal
// arithmetic on the BCD digits, independent of the shift/correct iteration.
module tb_bcd_to_bin_seq;
   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int LATENCY = BIN_W + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [BCD_W-1:0] bcd_in = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BIN_W-1:0] bin_out;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             busy;
   logic             err;

   int checks = 0;
   int errors = 0;

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bcd_in    (bcd_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_out   (bin_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int bcd_value(input logic [BCD_W-1:0] w);
      int v = 0;
      int scale = 1;
      for (int i = 0; i < DIGITS; i++) begin
         v += int'(w[4*i +: 4]) * scale;
         scale *= 10;
      end
      return v;
   endfunction

   function automatic bit bcd_legal(input logic [BCD_W-1:0] w);
      bit ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
   task automatic convert(input logic [BCD_W-1:0] word, input int hold_cycles, input bit jitter);
      int               wait_n;
      int               lat;
      int               shift_bad;
      int               stable_bad;
      bit               legal;
      logic             exp_err;
      logic [BIN_W-1:0] exp_bin;
      logic [BIN_W-1:0] held;
      legal   = bcd_legal(word);
      exp_bin = legal ? BIN_W'(bcd_value(word)) : '0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
      exp_err = !legal;
`else
      exp_err = 1'b0;
`endif
      out_ready = (hold_cycles == 0);
      in_valid  = 1'b1;
      bcd_in    = word;
      wait_n    = 0;
      while (!in_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      check("accept_in_time", 32'(wait_n < 50), 32'd1);

      lat = 0;
      shift_bad = 0;
      do begin
         @(negedge clk);
         lat++;
         if (jitter) bcd_in = BCD_W'($urandom);
         else        in_valid = 1'b0;
         if (!out_valid && (in_ready !== 1'b0 || busy !== 1'b1)) shift_bad++;
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
      bcd_in   = BCD_W'($urandom);

      check("busy_no_ready_in_shift", shift_bad, 0);
      check("latency", lat, LATENCY);
      check("out_valid", out_valid, 1);
`ifdef BCD_TO_BIN_ERR_CHECK_EN
      check("bin_out", bin_out, exp_bin);
`else
      if (legal) check("bin_out", bin_out, exp_bin);
`endif
      check("err", err, exp_err);

      held = bin_out;
      stable_bad = 0;
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         if (bin_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== exp_err)
            stable_bad++;
      end
      check("held_under_backpressure", stable_bad, 0);
      out_ready = 1'b1;

      @(negedge clk);
      check("out_valid_dropped", out_valid, 0);
      check("in_ready_after_hs", in_ready, 1);
      check("busy_after_hs", busy, 0);
      check("err_after_hs", err, 0);
      check("bin_out_kept", bin_out, held);
      $display("word %h hold %0d jitter %0d -> bin_out %0d err %0b latency %0d",
               word, hold_cycles, jitter, held, exp_err, lat);
   endtask

   initial begin
      int bad_valid;
      logic [BCD_W-1:0] w;

      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_bin_out", bin_out, 0);
      rst = 1'b0;
      @(negedge clk);

      convert(12'h999, 0, 1'b0);
      convert(12'h000, 0, 1'b0);
      convert(12'h255, 0, 1'b0);
      convert(12'h010, 0, 1'b0);
      convert(12'h128, 0, 1'b0);
      convert(12'h507, 20, 1'b0);

      // Abort a conversion with a one-cycle reset at cycle 5.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      bcd_in    = 12'h999;
      check("abort_accept_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_bin_out", bin_out, 0);
      check("abort_err", err, 0);
      bad_valid = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad_valid++;
      end
      check("abort_no_output", bad_valid, 0);
      $display("abort of word 999 at cycle 5 -> idle, no output");
      convert(12'h042, 0, 1'b0);

      convert(12'h1A3, 0, 1'b0);
      convert(12'h123, 0, 1'b0);
      convert(12'h864, 3, 1'b1);

      for (int n = 0; n < 24; n++) begin
         w = '0;
         for (int d = 0; d < DIGITS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) w[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
         convert(w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
